// File: rtl/lzss_token_feeder_pkg.sv
// Shared widths, token layout and the token-feeder FSM state type.
package lzss_token_feeder_pkg;

  localparam int unsigned SYMBOL_LENGTH   = 8;
  localparam int unsigned TOKEN_W         = 3 * SYMBOL_LENGTH;
  localparam int unsigned FLAGS_PER_GROUP = 8;
  localparam int unsigned IDX_W           = $clog2(FLAGS_PER_GROUP);

  typedef enum logic [2:0] {
    IDLE,
    FLAG,
    B0,
    B1,
    B2,
    PRESENT,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/lzss_token_assembler.sv
// Byte shift register that packs stream bytes into literal or match tokens.
module lzss_token_assembler
  import lzss_token_feeder_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [SYMBOL_LENGTH-1:0] byte_i,
  input  logic                     push_i,
  input  logic                     load_lit_i,
  input  logic                     load_match_i,
  output logic [TOKEN_W-1:0]       token_o,
  output logic                     literal_o
);

  logic [2*SYMBOL_LENGTH-1:0] sh_q;
  logic [TOKEN_W-1:0]         token_q;
  logic                       lit_q;

  // Match token is {b0,b1,b2}: the two shifted bytes land above the final byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q    <= '0;
      token_q <= '0;
      lit_q   <= 1'b0;
    end else begin
      if (push_i) sh_q <= {sh_q[SYMBOL_LENGTH-1:0], byte_i};
      if (load_lit_i) begin
        token_q <= {{(2*SYMBOL_LENGTH){1'b0}}, byte_i};
        lit_q   <= 1'b1;
      end else if (load_match_i) begin
        token_q <= {sh_q, byte_i};
        lit_q   <= 1'b0;
      end
    end
  end

  assign token_o   = token_q;
  assign literal_o = lit_q;

endmodule

// File: rtl/lzss_token_feeder.sv
// Parses a packed LZSS flag/token byte stream and presents tokens to lzss_decoder.
module lzss_token_feeder
  import lzss_token_feeder_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     start,
  input  logic [SYMBOL_LENGTH-1:0] s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [TOKEN_W-1:0]       dec_data_in,
  output logic                     dec_literal,
  output logic                     dec_data_ready,
  input  logic                     dec_new_data_rdy,
  output logic                     done,
  output logic                     err_trunc,
  output logic [CNT_W-1:0]         tok_count,
  output logic [CNT_W-1:0]         byte_count
);

  feeder_state_t             state_q;
  logic [FLAGS_PER_GROUP-1:0] flag_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      last_pend_q;
  logic                      s_ready_q;
  logic                      dec_vld_q;
  logic                      done_q;
  logic                      err_q;
  logic [CNT_W-1:0]          tok_q;
  logic [CNT_W-1:0]          byte_q;

  logic acc;
  logic push;
  logic load_lit;
  logic load_match;

  always_comb begin
    acc        = s_valid & s_ready_q;
    push       = acc & ((state_q == B0) | (state_q == B1));
    load_lit   = acc & (state_q == B0) & flag_q[idx_q];
    load_match = acc & (state_q == B2);
  end

  lzss_token_assembler u_asm (
    .clk_i        (clk),
    .rst_i        (rst_),
    .byte_i       (s_data),
    .push_i       (push),
    .load_lit_i   (load_lit),
    .load_match_i (load_match),
    .token_o      (dec_data_in),
    .literal_o    (dec_literal)
  );

  // s_ready/dec_data_ready are registered alongside every state change.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q     <= IDLE;
      flag_q      <= '0;
      idx_q       <= '0;
      last_pend_q <= 1'b0;
      s_ready_q   <= 1'b0;
      dec_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tok_q       <= '0;
      byte_q      <= '0;
    end else begin
      if (acc) byte_q <= byte_q + CNT_W'(1);
      unique case (state_q)
        IDLE, DONE: if (start) begin
          state_q     <= FLAG;
          s_ready_q   <= 1'b1;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          last_pend_q <= 1'b0;
          tok_q       <= '0;
          byte_q      <= '0;
        end
        FLAG: if (acc) begin
          flag_q <= s_data;
          idx_q  <= '0;
          if (s_last) begin
            state_q   <= DONE;
            s_ready_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            state_q <= B0;
          end
        end
        B0: if (acc) begin
          if (flag_q[idx_q]) begin
            state_q     <= PRESENT;
            s_ready_q   <= 1'b0;
            dec_vld_q   <= 1'b1;
            last_pend_q <= s_last;
          end else if (s_last) begin
            state_q   <= DONE;
            s_ready_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            state_q <= B1;
          end
        end
        B1: if (acc) begin
          if (s_last) begin
            state_q   <= DONE;
            s_ready_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            state_q <= B2;
          end
        end
        B2: if (acc) begin
          state_q     <= PRESENT;
          s_ready_q   <= 1'b0;
          dec_vld_q   <= 1'b1;
          last_pend_q <= s_last;
        end
        PRESENT: if (dec_new_data_rdy) begin
          tok_q     <= tok_q + CNT_W'(1);
          idx_q     <= idx_q + IDX_W'(1);
          dec_vld_q <= 1'b0;
          if (last_pend_q) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            last_pend_q <= 1'b0;
          end else begin
            state_q   <= (idx_q == IDX_W'(FLAGS_PER_GROUP - 1)) ? FLAG : B0;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          dec_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready        = s_ready_q;
  assign dec_data_ready = dec_vld_q;
  assign done           = done_q;
  assign err_trunc      = err_q;
  assign tok_count      = tok_q;
  assign byte_count     = byte_q;

endmodule

// File: tb/tb_lzss_token_feeder.sv
// Self-checking bench: streams parsed by a queue-based reference model, compared token by token.
module tb_lzss_token_feeder;

  logic        clk = 1'b0;
  logic        rst_;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [23:0] dec_data_in;
  logic        dec_literal;
  logic        dec_data_ready;
  logic        dec_new_data_rdy;
  logic        done;
  logic        err_trunc;
  logic [31:0] tok_count;
  logic [31:0] byte_count;

  int tests = 0;
  int fails = 0;

  logic [7:0]  stream_q[$];
  logic [24:0] exp_q[$];   // {literal, token}
  bit          exp_trunc;

  always #5 clk = ~clk;

  lzss_token_feeder #(.CNT_W(32)) dut (
    .clk              (clk),
    .rst_             (rst_),
    .start            (start),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .dec_data_in      (dec_data_in),
    .dec_literal      (dec_literal),
    .dec_data_ready   (dec_data_ready),
    .dec_new_data_rdy (dec_new_data_rdy),
    .done             (done),
    .err_trunc        (err_trunc),
    .tok_count        (tok_count),
    .byte_count       (byte_count)
  );

  // Reference parse: flag byte, then up to 8 tokens; a match needs 3 bytes left.
  task automatic build_model();
    int i = 0;
    int n = stream_q.size();
    logic [7:0] flag;
    exp_q.delete();
    exp_trunc = 0;
    while (i < n) begin
      flag = stream_q[i];
      i++;
      for (int b = 0; b < 8; b++) begin
        if (i >= n) break;
        if (flag[b]) begin
          exp_q.push_back({1'b1, 16'h0000, stream_q[i]});
          i++;
        end else begin
          if (n - i < 3) begin
            exp_trunc = 1;
            i = n;
            break;
          end
          exp_q.push_back({1'b0, stream_q[i], stream_q[i+1], stream_q[i+2]});
          i += 3;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives stream_q with s_valid holes, pulls tokens, checks them and final status.
  task automatic run_stream(input string name, input bit stall, input int gap_at, input bit rdy_always);
    int bi = 0;
    int got = 0;
    int n = stream_q.size();
    int stall_left = stall ? 5 : 0;
    int gap_left = (gap_at >= 0) ? 10 : 0;
    int cyc;
    build_model();
    pulse_start();
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (dec_data_ready === 1'b1) begin
        tests++;
        if (s_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s ready_overlap: s_ready=%b required 0 while token presented", name, s_ready);
        end
      end
      if (bi == gap_at && gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
        if (gap_left == 0) begin
          tests++;
          if (got != 8 || tok_count !== 32'd8 || dec_data_ready !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s wait_flag: got=%0d tok_count=%0d dec_data_ready=%b s_ready=%b required 8/8/0/1",
                     name, got, tok_count, dec_data_ready, s_ready);
          end
        end
      end else if (bi < n) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = stream_q[bi];
        s_last  = (bi == n - 1);
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready === 1'b1) bi++;
      if (dec_data_ready === 1'b1 && stall_left > 0) begin
        dec_new_data_rdy = 1'b0;
        stall_left--;
        tests++;
        if (got >= exp_q.size() || dec_data_in !== exp_q[got][23:0] || s_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s stall_hold: data=%h s_ready=%b required stable expected token, s_ready 0",
                   name, dec_data_in, s_ready);
        end
      end else begin
        dec_new_data_rdy = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (dec_data_ready === 1'b1 && dec_new_data_rdy) begin
        tests++;
        if (got >= exp_q.size()) begin
          fails++;
          $display("FAIL %s extra_token: data=%h required no token", name, dec_data_in);
        end else if ({dec_literal, dec_data_in} !== exp_q[got]) begin
          fails++;
          $display("FAIL %s token[%0d]: lit=%b data=%h required lit=%b data=%h",
                   name, got, dec_literal, dec_data_in, exp_q[got][24], exp_q[got][23:0]);
        end
        got++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    dec_new_data_rdy = 1'b0;
    tests++;
    if (done !== 1'b1 || got != exp_q.size()) begin
      fails++;
      $display("FAIL %s completion: done=%b tokens=%0d required done=1 tokens=%0d (cycles %0d)",
               name, done, got, exp_q.size(), cyc);
    end
    tests++;
    if (err_trunc !== exp_trunc) begin
      fails++;
      $display("FAIL %s err_trunc: got %b required %b", name, err_trunc, exp_trunc);
    end
    tests++;
    if (tok_count !== 32'(exp_q.size()) || byte_count !== 32'(n)) begin
      fails++;
      $display("FAIL %s counters: tok=%0d bytes=%0d required tok=%0d bytes=%0d",
               name, tok_count, byte_count, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; dec_new_data_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
    tests++;
    if ({s_ready, dec_data_ready, dec_literal, done, err_trunc} !== 5'b0 ||
        dec_data_in !== 24'h0 || tok_count !== 32'h0 || byte_count !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b dv=%b lit=%b done=%b err=%b data=%h tok=%0d bytes=%0d required all 0",
               s_ready, dec_data_ready, dec_literal, done, err_trunc, dec_data_in, tok_count, byte_count);
    end
  endtask

  task automatic test_all_literals();
    stream_q = {8'hFF, "A", "B", "C", "D", "E", "F", "G", "H"};
    run_stream("all_literals", 0, -1, 0);
  endtask

  task automatic test_all_matches();
    stream_q.delete();
    stream_q.push_back(8'h00);
    for (int i = 0; i < 24; i++) stream_q.push_back(8'($urandom_range(0, 255)));
    stream_q.push_back(8'h01);
    stream_q.push_back("Z");
    run_stream("all_matches", 0, 25, 1);
  endtask

  task automatic test_mixed_stall();
    stream_q = {8'h05, "a", 8'h10, 8'h20, 8'h30, "b", 8'h40, 8'h50, 8'h60};
    run_stream("mixed_stall", 1, -1, 0);
  endtask

  task automatic test_truncation();
    stream_q = {8'h00, 8'hAB, 8'hCD};
    run_stream("truncation", 0, -1, 0);
    stream_q = {8'h03, "x", "y", 8'h77};
    run_stream("trunc_b0", 0, -1, 0);
  endtask

  task automatic test_clean_end_restart();
    stream_q = {8'hFF, "p", "q", "r"};
    run_stream("clean_end", 0, -1, 0);
    stream_q = {8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_stream("flag_last_mid", 0, -1, 0);
    pulse_start();
    tests++;
    if (done !== 1'b0 || err_trunc !== 1'b0 || tok_count !== 32'h0 || byte_count !== 32'h0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear: done=%b err=%b tok=%0d bytes=%0d s_ready=%b required 0/0/0/0/1",
               done, err_trunc, tok_count, byte_count, s_ready);
    end
    stream_q = {8'h00};
    run_stream("flag_only", 0, -1, 0);
  endtask

  task automatic test_async_reset_mid();
    pulse_start();
    @(negedge clk); s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0;
    @(negedge clk); s_data = 8'h11;
    @(negedge clk); s_data = 8'h22; s_valid = 1'b0;
    #2 rst_ = 1'b1;
    s_valid = 1'b1;
    #1;
    tests++;
    if ({s_ready, dec_data_ready, dec_literal, done, err_trunc} !== 5'b0 ||
        dec_data_in !== 24'h0 || tok_count !== 32'h0 || byte_count !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b dv=%b done=%b err=%b tok=%0d bytes=%0d required all 0",
               s_ready, dec_data_ready, done, err_trunc, tok_count, byte_count);
    end
    @(negedge clk); s_valid = 1'b0;
    @(negedge clk); rst_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = (i % 2 == 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    tests++;
    if (s_ready !== 1'b0 || byte_count !== 32'h0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: s_ready=%b bytes=%0d done=%b required 0/0/0", s_ready, byte_count, done);
    end
    stream_q = {8'h02, 8'h01, 8'h02, 8'h03, "k"};
    run_stream("resume", 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      int len = $urandom_range(1, 40);
      stream_q.delete();
      for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom_range(0, 255)));
      run_stream($sformatf("random%0d", s), (s % 2) == 1, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_all_literals();
    test_all_matches();
    test_mixed_stall();
    test_truncation();
    test_clean_end_restart();
    test_async_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
